// File: rtl/gpio_pkg.sv
// Board-level constants shared by the GPIO peripheral and its input conditioner.
package gpio_pkg;
    localparam int GPIO_WIDTH         = 10;
    localparam int DEBOUNCE_1MS_50MHZ = 50000;
endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter, accepted level and edge pulses.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_next
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        s1_d     = raw_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Any sample matching the accepted level restarts the count.
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign clean_out   = stable_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign change_next = rise_d | fall_d;
endmodule

// File: rtl/gpio_debounce.sv
// Debounced input conditioner feeding the GPIO in_port, with per-bit edge pulses
// and a combined change strobe for the timer control logic.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    logic [WIDTH-1:0] change_next;
    logic             any_change_q, any_change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .raw_in     (raw_in[i]),
            .clean_out  (clean_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .change_next(change_next[i])
        );
    end

    // OR the next-cycle pulses so any_change lands on the same edge as the pulses.
    always_comb begin
        any_change_d = |change_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;
endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: main instance with DEBOUNCE_CYCLES=4, plus a
// narrow instance with DEBOUNCE_CYCLES=1.
module tb_gpio_debounce;
    logic       clk;
    logic       reset;
    logic [9:0] raw_in;
    logic [9:0] clean_out;
    logic [9:0] rise_pulse;
    logic [9:0] fall_pulse;
    logic       any_change;

    logic [1:0] raw1;
    logic [1:0] clean1;
    logic [1:0] rise1;
    logic [1:0] fall1;
    logic       any1;

    int checks   = 0;
    int failures = 0;

    gpio_debounce #(
        .WIDTH          (10),
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    gpio_debounce #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw1),
        .clean_out (clean1),
        .rise_pulse(rise1),
        .fall_pulse(fall1),
        .any_change(any1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] c, input logic [9:0] r,
                           input logic [9:0] f);
        chk({tag, "_clean"}, 32'(clean_out), 32'(c));
        chk({tag, "_rise"}, 32'(rise_pulse), 32'(r));
        chk({tag, "_fall"}, 32'(fall_pulse), 32'(f));
        chk({tag, "_any"}, 32'(any_change), 32'((r | f) != 10'h000));
    endtask

    task automatic quiet(input string tag, input int n, input logic [9:0] c);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_all(tag, c, 10'h000, 10'h000);
        end
    endtask

    task automatic edge_chk(input string tag, input logic [9:0] c, input logic [9:0] r,
                            input logic [9:0] f);
        tick();
        chk_all(tag, c, r, f);
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 10'h000;
        raw1   = 2'b00;
        repeat (3) tick();
        chk_all("reset_state", 10'h000, 10'h000, 10'h000);
        chk("reset_state_clean1", 32'(clean1), 32'h0);
        reset = 1'b0;

        // DEBOUNCE_CYCLES=1: change at edge k, accepted at edge k+2.
        tick();
        raw1 = 2'b01;
        tick();
        chk("d1_k_clean", 32'(clean1), 32'h0);
        tick();
        chk("d1_k1_clean", 32'(clean1), 32'h0);
        tick();
        chk("d1_rise_clean", 32'(clean1), 32'h1);
        chk("d1_rise_pulse", 32'(rise1), 32'h1);
        chk("d1_rise_any", 32'(any1), 32'h1);
        tick();
        chk("d1_rise_done", 32'(rise1), 32'h0);
        raw1 = 2'b00;
        tick();
        tick();
        chk("d1_fall_early", 32'(fall1), 32'h0);
        tick();
        chk("d1_fall_clean", 32'(clean1), 32'h0);
        chk("d1_fall_pulse", 32'(fall1), 32'h1);
        chk("d1_fall_rise", 32'(rise1), 32'h0);

        // Power-up style: all inputs high.
        raw_in = 10'h3FF;
        quiet("pwr_wait", 5, 10'h000);
        edge_chk("pwr_edge", 10'h3FF, 10'h3FF, 10'h000);
        quiet("pwr_hold", 1, 10'h3FF);

        // Asynchronous reset mid-cycle, then release and re-debounce.
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 10'h000, 10'h000, 10'h000);
        #1 reset = 1'b0;
        quiet("rst_rel_wait", 5, 10'h000);
        edge_chk("rst_rel_edge", 10'h3FF, 10'h3FF, 10'h000);
        quiet("rst_rel_hold", 1, 10'h3FF);

        raw_in = 10'h000;
        quiet("all_fall_wait", 5, 10'h3FF);
        edge_chk("all_fall_edge", 10'h000, 10'h000, 10'h3FF);
        quiet("all_fall_hold", 1, 10'h000);

        // Clean step on bit0.
        raw_in = 10'h001;
        quiet("step_wait", 5, 10'h000);
        edge_chk("step_edge", 10'h001, 10'h001, 10'h000);
        quiet("step_hold", 2, 10'h001);

        // Bit3 bounces with 3-cycle phases, then settles high.
        for (int b = 0; b < 2; b++) begin
            raw_in = 10'h009;
            quiet("bounce_hi", 3, 10'h001);
            raw_in = 10'h001;
            quiet("bounce_lo", 3, 10'h001);
        end
        raw_in = 10'h009;
        quiet("settle_wait", 5, 10'h001);
        edge_chk("settle_edge", 10'h009, 10'h008, 10'h000);
        quiet("settle_hold", 1, 10'h009);

        // Bit5 high, then a one-cycle low glitch.
        raw_in = 10'h029;
        quiet("b5_wait", 5, 10'h009);
        edge_chk("b5_edge", 10'h029, 10'h020, 10'h000);
        raw_in = 10'h009;
        quiet("glitch", 1, 10'h029);
        raw_in = 10'h029;
        quiet("glitch_after", 8, 10'h029);

        // Bits 2 and 7 rise, then fall together.
        raw_in = 10'h0AD;
        quiet("sim_rise_wait", 5, 10'h029);
        edge_chk("sim_rise_edge", 10'h0AD, 10'h084, 10'h000);
        raw_in = 10'h029;
        quiet("sim_fall_wait", 5, 10'h0AD);
        edge_chk("sim_fall_edge", 10'h029, 10'h000, 10'h084);
        quiet("sim_fall_hold", 1, 10'h029);

        // Bit1 counts for 3 cycles, then reset discards the count.
        raw_in = 10'h02B;
        quiet("midcnt_wait", 5, 10'h029);
        #2 reset = 1'b1;
        #1 chk_all("midcnt_rst", 10'h000, 10'h000, 10'h000);
        #1 reset = 1'b0;
        quiet("midcnt_rel_wait", 5, 10'h000);
        edge_chk("midcnt_rel_edge", 10'h02B, 10'h02B, 10'h000);
        quiet("midcnt_rel_hold", 1, 10'h02B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
